// File: rtl/aes_sched_pkg.sv
// Shared types and constants for the AES serial job scheduler.
//   state_e  : scheduler FSM states
//   MODE_*   : job mode encoding (0 = encrypt, 1 = decrypt)
//   BLK_W    : block/key width, fixed at 128
//   CNT_W    : width of the shared per-state cycle counter
package aes_sched_pkg;

    localparam int   BLK_W    = 128;
    localparam int   CNT_W    = 8;
    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND_DATA,
        ST_SEND_KEY,
        ST_WAIT,
        ST_RECV,
        ST_DONE
    } state_e;

endpackage

// File: rtl/aes_sched_shreg.sv
// 128-bit shift register with parallel load, serial LSB-first output and
// serial input entering at the MSB. Load has priority over shift.
// Ports:
//   clk, reset   : clock, synchronous active-high reset (clears contents)
//   load_i       : parallel load of load_data_i
//   shift_i      : shift right by one, ser_i enters bit BLK_W-1
//   ser_o        : current bit 0
//   par_o        : full register contents
module aes_sched_shreg
    import aes_sched_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [BLK_W-1:0] load_data_i,
    input  logic             shift_i,
    input  logic             ser_i,
    output logic             ser_o,
    output logic [BLK_W-1:0] par_o
);

    logic [BLK_W-1:0] shreg_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            shreg_q <= '0;
        end else if (load_i) begin
            shreg_q <= load_data_i;
        end else if (shift_i) begin
            shreg_q <= {ser_i, shreg_q[BLK_W-1:1]};
        end
    end

    assign ser_o = shreg_q[0];
    assign par_o = shreg_q;

endmodule

// File: rtl/aes_spi_scheduler.sv
// Two-requester job scheduler for the bit-serial AES encrypt/decrypt engines.
// Accepts a 128-bit block + key, shifts both LSB-first onto the shared serial
// line, waits WAIT_CYCLES, deserializes the selected engine's result and
// presents it with a valid/ready handshake.
//
// Build option: AES_SCHED_RR_EN selects round-robin arbitration on a tie;
// without it requester 0 wins every tie and no pointer register exists.
//
// state      | meaning
// -----------+-------------------------------------------------------
// IDLE       | waiting for a request, arbiter drives req*_ready
// SEND_DATA  | data block on spi_in, LSB first, 128 cycles
// SEND_KEY   | key on spi_in, LSB first, 128 cycles
// WAIT       | spi_in low for WAIT_CYCLES cycles (engine latency)
// RECV       | engine out sampled into rsp_data[cnt], 128 cycles
// DONE       | rsp_valid high until rsp_ready
//
// Ports:
//   clk, reset                    : clock, synchronous active-high reset
//   reqN_valid/ready/mode/data/key: requester N job interface (N = 0, 1)
//   rsp_valid/ready/id/data       : result handshake
//   spi_in                        : serial line shared by both engines
//   enc_/dec_enable, enc_/dec_chip: engine enable and active-low select
//   enc_/dec_out                  : engine serial result
//   busy                          : high outside IDLE
module aes_spi_scheduler
    import aes_sched_pkg::*;
#(
    parameter int WAIT_CYCLES = 20    // legal range 1..255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic             req0_mode,
    input  logic [BLK_W-1:0] req0_data,
    input  logic [BLK_W-1:0] req0_key,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic             req1_mode,
    input  logic [BLK_W-1:0] req1_data,
    input  logic [BLK_W-1:0] req1_key,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [BLK_W-1:0] rsp_data,
    output logic             spi_in,
    output logic             enc_enable,
    output logic             dec_enable,
    output logic             enc_chip,
    output logic             dec_chip,
    input  logic             enc_out,
    input  logic             dec_out,
    output logic             busy
);

    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(BLK_W - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             mode_q;
    logic             rsp_id_q;
    logic [BLK_W-1:0] key_q;
    logic             enc_sel_q;
    logic             dec_sel_q;
    logic             rsp_valid_q;
    logic             busy_q;

    logic             idle;
    logic             pick1;
    logic             accept;
    logic             acc_mode;
    logic [BLK_W-1:0] acc_data;
    logic [BLK_W-1:0] acc_key;

    logic             tx_load;
    logic             tx_shift;
    logic [BLK_W-1:0] tx_load_data;
    logic             rx_shift;
    logic             rx_ser;
    logic [BLK_W-1:0] unused_tx_par;
    logic             unused_rx_ser;

    // ---------------- arbitration ----------------
    assign idle = (state_q == ST_IDLE);

`ifdef AES_SCHED_RR_EN
    logic last_q;    // requester accepted most recently

    // Reset value 1 makes requester 0 win the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= 1'b1;
        end else if (accept) begin
            last_q <= pick1;
        end
    end

    assign pick1 = req1_valid && (!req0_valid || !last_q);
`else
    assign pick1 = req1_valid && !req0_valid;
`endif

    assign req0_ready = idle && req0_valid && !pick1;
    assign req1_ready = idle && pick1;
    assign accept     = idle && (req0_valid || req1_valid);

    assign acc_mode = pick1 ? req1_mode : req0_mode;
    assign acc_data = pick1 ? req1_data : req0_data;
    assign acc_key  = pick1 ? req1_key  : req0_key;

    // ---------------- datapath ----------------
    // The data block is loaded on accept; the key replaces it on the last
    // data bit. Zeros shift in behind the key, so spi_in idles low in WAIT.
    assign tx_load      = accept || (state_q == ST_SEND_DATA && cnt_q == LAST_BIT);
    assign tx_load_data = idle ? acc_data : key_q;
    assign tx_shift     = (state_q == ST_SEND_DATA) || (state_q == ST_SEND_KEY);

    assign rx_shift = (state_q == ST_RECV);
    assign rx_ser   = (mode_q == MODE_DEC) ? dec_out : enc_out;

    aes_sched_shreg u_tx (
        .clk         (clk),
        .reset       (reset),
        .load_i      (tx_load),
        .load_data_i (tx_load_data),
        .shift_i     (tx_shift),
        .ser_i       (1'b0),
        .ser_o       (spi_in),
        .par_o       (unused_tx_par)
    );

    // First sampled bit ends up in bit 0 after 128 shifts.
    aes_sched_shreg u_rx (
        .clk         (clk),
        .reset       (reset),
        .load_i      (1'b0),
        .load_data_i ('0),
        .shift_i     (rx_shift),
        .ser_i       (rx_ser),
        .ser_o       (unused_rx_ser),
        .par_o       (rsp_data)
    );

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            mode_q      <= MODE_ENC;
            rsp_id_q    <= 1'b0;
            key_q       <= '0;
            enc_sel_q   <= 1'b0;
            dec_sel_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_q   <= ST_SEND_DATA;
                        cnt_q     <= '0;
                        mode_q    <= acc_mode;
                        rsp_id_q  <= pick1;
                        key_q     <= acc_key;
                        enc_sel_q <= (acc_mode == MODE_ENC);
                        dec_sel_q <= (acc_mode == MODE_DEC);
                        busy_q    <= 1'b1;
                    end
                end
                ST_SEND_DATA: begin
                    if (cnt_q == LAST_BIT) begin
                        state_q <= ST_SEND_KEY;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                ST_SEND_KEY: begin
                    if (cnt_q == LAST_BIT) begin
                        state_q <= ST_WAIT;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == WAIT_LAST) begin
                        state_q <= ST_RECV;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                ST_RECV: begin
                    if (cnt_q == LAST_BIT) begin
                        state_q     <= ST_DONE;
                        cnt_q       <= '0;
                        enc_sel_q   <= 1'b0;
                        dec_sel_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                ST_DONE: begin
                    if (rsp_ready) begin
                        state_q     <= ST_IDLE;
                        cnt_q       <= '0;
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign busy       = busy_q;
    assign enc_enable = enc_sel_q;
    assign dec_enable = dec_sel_q;
    assign enc_chip   = !enc_sel_q;
    assign dec_chip   = !dec_sel_q;

endmodule

// File: doc/aes_spi_scheduler.md
# aes_spi_scheduler

Two-requester job scheduler for the bit-serial AES engines (`SpiAes` encrypt, `SpiAesdecryption` decrypt). It accepts parallel 128-bit block/key jobs and arbitrates between the two requesters. It shifts the block and key serially into the selected engine, waits out the engine latency, deserializes the result and returns it with a valid/ready handshake. It sits between the bus-side requesters and the two engine instances, which share one serial input line.

## Interface
- `BLK_W`, 128: block and key width; fixed at 128.
- `WAIT_CYCLES`, 20: cycles between last key bit and first result bit; legal range 1..255.
- `clk` in 1: sole clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `req0_valid` / `req1_valid` in 1: job request from requester 0 / 1.
- `req0_ready` / `req1_ready` out 1: job accepted when valid&ready on the same edge.
- `req0_mode` / `req1_mode` in 1: 0 = encrypt, 1 = decrypt.
- `req0_data` / `req1_data` in 128: plaintext or ciphertext.
- `req0_key` / `req1_key` in 128: AES-128 key.
- `rsp_valid` out 1: result available.
- `rsp_ready` in 1: consumer accepts the result.
- `rsp_id` out 1: requester that owns the result.
- `rsp_data` out 128: engine result.
- `spi_in` out 1: serial line to both engines' `in`.
- `enc_enable` / `dec_enable` out 1: engine `enable`.
- `enc_chip` / `dec_chip` out 1: engine `chip`, active-low select.
- `enc_out` / `dec_out` in 1: engine serial `out`.
- `busy` out 1: high in every state except IDLE.

## Operation
- States: IDLE, SEND_DATA, SEND_KEY, WAIT, RECV, DONE.
- One 8-bit counter is shared by all states. It is cleared on every state entry.
- IDLE:
  - The arbiter picks a requester among the asserted valids.
  - Only the picked requester sees `ready`=1.
  - On accept, data, key, mode and id are captured, and the state goes to SEND_DATA.
  - Requester inputs may change after the accept.
- SEND_DATA: `spi_in` = data[cnt], LSB first, for 128 cycles. Then go to SEND_KEY.
- SEND_KEY: `spi_in` = key[cnt], LSB first, for 128 cycles. Then go to WAIT.
- WAIT: `spi_in`=0 for WAIT_CYCLES cycles. Then go to RECV.
- RECV:
  - The selected engine's `out` is sampled into `rsp_data[cnt]` at the end of each cycle, for 128 cycles.
  - Then go to DONE.
- DONE:
  - `rsp_valid`=1, with `rsp_data` and `rsp_id` stable until `rsp_ready`.
  - The cycle where `rsp_valid` and `rsp_ready` are both high returns the block to IDLE.
  - No accept happens in that same cycle.
- Engine select:
  - From SEND_DATA through RECV, the selected engine has chip=0 and enable=1.
  - The other engine has chip=1 and enable=0.
  - In IDLE and DONE both engines have chip=1 and enable=0.
- Arbitration:
  - Only one valid asserted: that requester wins.
  - Both asserted: the policy is set by the macro under Configuration.
- Reset:
  - `reset` mid-job aborts the job; no response is produced.
  - Next cycle: state IDLE, counter 0.
  - Outputs after reset: `spi_in`=0, both chips=1, both enables=0, `rsp_valid`=0, `rsp_id`=0, `rsp_data`=0, `busy`=0, both readys 0.
  - The round-robin pointer is reset to favour requester 0.

## Timing
- Accept edge T. SEND_DATA covers cycles T+1..T+128.
- SEND_KEY covers T+129..T+256.
- WAIT covers T+257..T+256+W, where W = WAIT_CYCLES.
- RECV covers T+257+W..T+384+W.
- `rsp_valid` rises at T+385+W, i.e. cycle 405 for the default W.
- `readyN` is combinational from IDLE state and the arbiter.
- The earliest next accept is the cycle after the rsp handshake.
- Throughput is one job per 386+W cycles when the consumer is always ready.

## Configuration
- `AES_SCHED_RR_EN`:
  - Defined: round-robin arbitration. When both are valid, the requester not served last wins. The pointer updates on each accept.
  - Undefined: fixed priority; requester 0 always wins a tie, and no pointer register exists.

## Structure
- Package `aes_sched_pkg` holds:
  - the state enum;
  - the `MODE_ENC`/`MODE_DEC` constants;
  - `BLK_W`;
  - the counter width constant.
- Sub-module `aes_sched_shreg`: a 128-bit shift register with parallel load, serial LSB-first out and serial in. It is instantiated for the TX data/key path and the RX result path.

## Test plan
- Encrypt: req0, mode 0, data 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f.
  - Required: `rsp_data`=69c4e0d86a7b0430d8cdb78070b4c55a, `rsp_id`=0, `rsp_valid` at T+405.
- Decrypt: req1, mode 1, data 69c4e0d86a7b0430d8cdb78070b4c55a, same key.
  - Required: `rsp_data`=00112233445566778899aabbccddeeff, `rsp_id`=1, `dec_chip`=0 and `enc_chip`=1 throughout the job.
- Tie: both valid continuously for three jobs.
  - With the macro defined, grant order is 0,1,0.
  - With it undefined, grant order is 0,0,0.
- Backpressure: hold `rsp_ready`=0 for 50 cycles after `rsp_valid`.
  - Required: `rsp_data` stable, both readys 0, `busy`=1.
  - Release: IDLE the next cycle.
- Reset in WAIT, then resubmit the encrypt job.
  - Required: after reset, all outputs match the reset values.
  - The resubmitted job completes with the correct ciphertext.
